// File: rtl/data_recv.sv
// data_recv: UART-format serial byte receiver (8N1, LSB first).
// Define DATA_RECV_PARITY_EN to add an even-parity bit and parity_err.
`timescale 1ns/1ps
module data_recv #(
    parameter int CLKS_PER_BIT = 108,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
`ifdef DATA_RECV_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    sync_q, sync_d;
    logic          rxd_s;
`ifdef DATA_RECV_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    assign rxd_s      = sync_q[1];
    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = (state_q != IDLE);
`ifdef DATA_RECV_PARITY_EN
    assign parity_err = perr_q;
`endif

    // Frame sequencing: mid-bit sampling driven by the per-bit counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        sync_d  = {sync_q[0], rxd};
`ifdef DATA_RECV_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef DATA_RECV_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
`ifdef DATA_RECV_PARITY_EN
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    par_d   = rxd_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        state_d = IDLE;
`ifdef DATA_RECV_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            dout_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        dout_d  = shift_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
`ifdef DATA_RECV_PARITY_EN
                        perr_d  = ^{shift_q, par_q};
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and synchronizer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 2'b11;
`ifdef DATA_RECV_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            sync_q  <= sync_d;
`ifdef DATA_RECV_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

endmodule
